// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: encoder state encoding and default bit timings
// (200 MHz clock), also used by the frame controller's reset-gap budget.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ws2812_state_t;

  localparam logic [7:0] T0H_DEF = 8'd80;
  localparam logic [7:0] T0L_DEF = 8'd170;
  localparam logic [7:0] T1H_DEF = 8'd160;
  localparam logic [7:0] T1L_DEF = 8'd90;

  // 50 us line-low reset gap in 200 MHz cycles.
  localparam int unsigned CNT_50_US = 10000;

  // Counter load for a phase of 'c0' (bit 0) or 'c1' (bit 1) cycles.
  function automatic logic [7:0] phase_load(input logic b, input logic [7:0] c0,
                                            input logic [7:0] c1);
    return (b ? c1 : c0) - 8'd1;
  endfunction

endpackage

// File: rtl/ws2812_code.sv
// WS2812 single-bit NRZ encoder: one bit per strobe, high phase then low phase,
// with a registered one-cycle done pulse in the last low cycle.
module ws2812_code
  import ws2812_pkg::*;
#(
  parameter logic [7:0] T0H_CNT = T0H_DEF,
  parameter logic [7:0] T0L_CNT = T0L_DEF,
  parameter logic [7:0] T1H_CNT = T1H_DEF,
  parameter logic [7:0] T1L_CNT = T1L_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       bit_rdy_in,
  input  logic       bit_data_in,
  output logic       bit_done_out,
  output logic       ws2812_data_out,
  output logic       err_ovf_out,
  output logic [1:0] state_dbg_out
);

  // Handshake: a bit_rdy_in strobe is accepted only in IDLE or in the cycle
  // bit_done_out is high; any other strobe is dropped and sets err_ovf_out.
  ws2812_state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          bit_q, bit_d;
  logic          err_q, err_d;
  logic          line_q, line_d;
  logic          done_q, done_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bit_rdy_in) begin
          bit_d   = bit_data_in;
          cnt_d   = phase_load(bit_data_in, T0H_CNT, T1H_CNT);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (bit_rdy_in) err_d = 1'b1;
        if (cnt_zero) begin
          cnt_d   = phase_load(bit_q, T0L_CNT, T1L_CNT);
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          if (bit_rdy_in) begin
            bit_d   = bit_data_in;
            cnt_d   = phase_load(bit_data_in, T0H_CNT, T1H_CNT);
            state_d = HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bit_rdy_in) err_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so the pin has no comb path.
    line_d = (state_d == HIGH);
    done_d = (state_d == LOW) && (cnt_d == 8'd0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  assign ws2812_data_out = line_q;
  assign bit_done_out    = done_q;
  assign err_ovf_out     = err_q;
  assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_ws2812_code.sv
// Self-checking bench for ws2812_code: random bit stream against a timing
// model; a monitor measures each emitted bit and checks it against exp_q.
module tb_ws2812_code;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       bit_rdy_in = 1'b0;
  logic       bit_data_in = 1'b0;
  logic       bit_done_out;
  logic       ws2812_data_out;
  logic       err_ovf_out;
  logic [1:0] state_dbg_out;

  ws2812_code dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .bit_rdy_in      (bit_rdy_in),
    .bit_data_in     (bit_data_in),
    .bit_done_out    (bit_done_out),
    .ws2812_data_out (ws2812_data_out),
    .err_ovf_out     (err_ovf_out),
    .state_dbg_out   (state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  localparam int W = 48;   // {first high cycle[31:0], high len[7:0], low len[7:0]}
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int busy_until = 0;           // model: cycle in which the current bit's done is due
  int err_cyc = 32'h7fffffff;   // model: first cycle err_ovf_out must be high

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(input logic b);
    int th, tl;
    bit_rdy_in  = 1'b1;
    bit_data_in = b;
    if (cyc >= busy_until) begin
      th = b ? 160 : 80;
      tl = b ? 90 : 170;
      exp_q.push_back({32'(cyc + 1), 8'(th), 8'(tl)});
      busy_until = cyc + th + tl;
    end else if (err_cyc > cyc + 1) begin
      err_cyc = cyc + 1;
    end
    @(posedge clk_in);
    #1;
    bit_rdy_in  = 1'b0;
    bit_data_in = 1'($urandom);
  endtask

  task automatic send(input logic b, input int gap);
    wait_until(busy_until + gap);
    strobe(b);
  endtask

  // ---------------- monitor ----------------
  logic prev_line = 1'b0;
  logic prev_done = 1'b0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;

  always @(negedge clk_in) begin
    logic [W-1:0] e;
    if (!rst_n_in) begin
      if (ws2812_data_out || bit_done_out || err_ovf_out) begin
        check("outputs_in_reset", int'({ws2812_data_out, bit_done_out, err_ovf_out}), 0);
      end
      prev_line = 1'b0;
      prev_done = 1'b0;
      rise_cyc  = -1;
      fall_cyc  = -1;
    end else begin
      check("err_ovf", int'(err_ovf_out), int'(cyc >= err_cyc));
      if (!prev_line && ws2812_data_out) rise_cyc = cyc;
      if (prev_line && !ws2812_data_out) fall_cyc = cyc;
      if (bit_done_out) begin
        if (prev_done) check("done_double_pulse", 1, 0);
        check("line_low_at_done", int'(ws2812_data_out), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("bit_start_cycle", rise_cyc, int'(e[47:16]));
          check("high_width", fall_cyc - rise_cyc, int'(e[15:8]));
          check("low_width", cyc - fall_cyc + 1, int'(e[7:0]));
        end
      end
      prev_line = ws2812_data_out;
      prev_done = bit_done_out;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int activity;
    int k;
    wait_cyc(5);
    check("reset_line", int'(ws2812_data_out), 0);
    check("reset_done", int'(bit_done_out), 0);
    check("reset_err", int'(err_ovf_out), 0);
    rst_n_in = 1'b1;

    activity = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_cyc(1);
      if (ws2812_data_out || bit_done_out || err_ovf_out) activity++;
    end
    check("idle_activity", activity, 0);

    // single 0, single 1, then back-to-back 1,0,1 in the done cycle
    send(1'b0, 3);
    send(1'b1, 5);
    send(1'b1, 4);
    send(1'b0, 0);
    send(1'b1, 0);

    // overrun 20 cycles into a 1 bit
    send(1'b1, 2);
    wait_cyc(19);
    strobe(1'b0);
    wait_cyc(1);
    check("err_after_overrun", int'(err_ovf_out), 1);
    wait_until(busy_until + 20);
    check("err_sticky", int'(err_ovf_out), 1);

    // reset 50 cycles into the high phase of a bit
    send(1'b0, 1);
    wait_cyc(49);
    #3;
    rst_n_in = 1'b0;
    exp_q.delete();
    busy_until = 0;
    err_cyc = 32'h7fffffff;
    #1;
    check("async_reset_line", int'(ws2812_data_out), 0);
    check("async_reset_done", int'(bit_done_out), 0);
    wait_cyc(3);
    rst_n_in = 1'b1;
    wait_cyc(300);
    send(1'b1, 2);
    send(1'b0, 0);

    // random stream with random turnaround and occasional overruns
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom), $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 200);
        wait_cyc(k);
        strobe(1'($urandom));
      end
    end

    wait_until(busy_until + 10);
    check("queue_drained", exp_q.size(), 0);
    check("final_line_low", int'(ws2812_data_out), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
